// File: rtl/pc_redirect_arbiter_pkg.sv
// Shared types and constants for the PC redirect arbiter: FSM states,
// redirect source indices and target alignment.
package pc_redirect_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Source index doubles as age: lower index = older pipeline stage.
  localparam int unsigned SRC_TRAP   = 0;
  localparam int unsigned SRC_XRET   = 1;
  localparam int unsigned SRC_BRANCH = 2;
  localparam int unsigned SRC_JUMP   = 3;

  // Number of low target-address bits forced to zero.
  localparam int unsigned ALIGN_BITS = 2;

endpackage

// File: rtl/pc_redirect_arbiter_prio_enc_lsb.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request
// plus an any-request flag.
module prio_enc_lsb #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/pc_redirect_arbiter.sv
// Age-ordered PC redirect arbiter driving the PCU jump interface, with a
// post-issue drain window in which only older requests may preempt.
module pc_redirect_arbiter
  import pc_redirect_arbiter_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int AW           = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     halt_i,
  input  logic [N_SRC-1:0]         req_i,
  input  logic [N_SRC*AW-1:0]      addr_i,
  output logic [N_SRC-1:0]         ack_o,
  output logic [N_SRC-1:0]         taken_o,
  input  logic                     pcu_ready_i,
  output logic                     jump_flag_o,
  output logic [AW-1:0]            jump_addr_o,
  output logic [$clog2(N_SRC)-1:0] grant_idx_o,
  output logic                     busy_o
);

  localparam int IW = $clog2(N_SRC);
  localparam int CW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  arb_state_e     state_q, state_d;
  logic           flag_q, flag_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [IW-1:0]    sel;
  logic             sel_any;
  logic [N_SRC-1:0] older_mask;
  logic [N_SRC-1:0] younger;
  logic             older_any;
  logic             load;
  logic [AW-1:0]    addr_arr [N_SRC];

  prio_enc_lsb #(.N(N_SRC), .IW(IW)) u_sel (
    .req_i (req_i),
    .idx_o (sel),
    .any_o (sel_any)
  );

  for (genvar g = 0; g < N_SRC; g++) begin : g_addr
    assign addr_arr[g] = addr_i[g*AW +: AW];
  end

  always_comb begin
    for (int j = 0; j < N_SRC; j++) older_mask[j] = (j < int'(grant_q));
  end

  assign younger   = req_i & ~older_mask;
  assign older_any = |(req_i & older_mask);

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    ack_o   = '0;
    taken_o = '0;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!halt_i && sel_any) load = 1'b1;
      end
      ST_ISSUE: begin
        ack_o = younger;
        if (older_any) begin
          load = 1'b1;
        end else if (pcu_ready_i) begin
          flag_d = 1'b0;
          if (DRAIN_CYCLES == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_DRAIN: begin
        ack_o = younger;
        if (older_any) begin
          load = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // When older requests exist, sel is necessarily one of them.
    if (load) begin
      ack_o[sel]   = 1'b1;
      taken_o[sel] = 1'b1;
      flag_d       = 1'b1;
      addr_d       = {addr_arr[sel][AW-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
      grant_d      = sel;
      state_d      = ST_ISSUE;
    end

    // A request cycle cut short by reset must not look consumed to the source.
    if (reset) begin
      ack_o   = '0;
      taken_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
      addr_q  <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

  assign jump_flag_o = flag_q;
  assign jump_addr_o = addr_q;
  assign grant_idx_o = grant_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule
